conv_frame_sequencer: RTL and testbench

// - Top-level scheduler for the 3x3 convolution datapath.
// - Takes a start request plus frame dimensions from the host.
// - Issues the one-cycle strobes (coeff_load_en, sample_load_en, new_row) that drive conv_controller.
// - Paces each strobe on controller modwait, walks a column/band raster, and generates sample-memory addresses.
// - Reports busy/done/err; a watchdog catches a hung controller.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_raster_counter.sv | 60 ++++++
 rtl/conv_frame_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_conv_frame_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution frame sequencer.
package conv_pkg;

   localparam int KERNEL_DIM  = 3;
   localparam int KERNEL_TAPS = KERNEL_DIM * KERNEL_DIM;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      COEFF_REQ  = 3'd1,
      COEFF_WAIT = 3'd2,
      COL_REQ    = 3'd3,
      COL_WAIT   = 3'd4,
      BAND_REQ   = 3'd5,
      END_REQ    = 3'd6,
      END_WAIT   = 3'd7
   } seq_state_t;

   function automatic logic is_wait_state(input seq_state_t s);
      return (s == COEFF_WAIT) || (s == COL_WAIT) || (s == END_WAIT);
   endfunction

endpackage

// File: rtl/conv_raster_counter.sv
// Column/band raster position for the frame walk, with last-column and
// last-band flags against the dimensions latched at frame start.
import conv_pkg::*;

module conv_raster_counter #(
   parameter int COL_W = 6,
   parameter int ROW_W = 6
) (
   input  logic             i_clk,
   input  logic             i_n_rst,
   input  logic             i_clear,
   input  logic             i_col_step,
   input  logic             i_band_step,
   input  logic [COL_W-1:0] i_col_last_idx,
   input  logic [ROW_W-1:0] i_band_last_idx,
   output logic [COL_W-1:0] o_col_nxt,
   output logic [ROW_W-1:0] o_band_nxt,
   output logic             o_col_last,
   output logic             o_band_last
);

   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_band;
   logic [COL_W-1:0] w_col_nxt;
   logic [ROW_W-1:0] w_band_nxt;

   // Next position; exposed so the caller can register strobe addresses in step.
   always_comb begin
      w_col_nxt  = r_col;
      w_band_nxt = r_band;
      if (i_clear) begin
         w_col_nxt  = {COL_W{1'b0}};
         w_band_nxt = {ROW_W{1'b0}};
      end else if (i_band_step) begin
         w_col_nxt  = {COL_W{1'b0}};
         w_band_nxt = r_band + ROW_W'(1);
      end else if (i_col_step) begin
         w_col_nxt  = r_col + COL_W'(1);
      end else begin
         w_col_nxt  = r_col;
      end
   end

   // Position register.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_col  <= {COL_W{1'b0}};
         r_band <= {ROW_W{1'b0}};
      end else begin
         r_col  <= w_col_nxt;
         r_band <= w_band_nxt;
      end
   end

   assign o_col_nxt   = w_col_nxt;
   assign o_band_nxt  = w_band_nxt;
   assign o_col_last  = (r_col == i_col_last_idx);
   assign o_band_last = (r_band == i_band_last_idx);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame scheduler for the 3x3 convolution datapath: issues controller strobes
// paced on modwait, walks the column/band raster and reports busy/done/err.
import conv_pkg::*;

module conv_frame_sequencer #(
   parameter int COL_W   = 6,
   parameter int ROW_W   = 6,
   parameter int TIMEOUT = 15
) (
   input  logic             i_clk,
   input  logic             i_n_rst,
   input  logic             i_start,
   input  logic [COL_W-1:0] i_img_cols,
   input  logic [ROW_W-1:0] i_img_rows,
   input  logic             i_modwait,
   input  logic             i_convolve_en,
   output logic             o_coeff_load_en,
   output logic             o_sample_load_en,
   output logic             o_new_row,
   output logic [COL_W-1:0] o_samp_col,
   output logic [ROW_W-1:0] o_samp_band,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   localparam int RES_W = COL_W + ROW_W;
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   seq_state_t       r_state, w_next_state;
   logic [COL_W-1:0] r_col_last_idx;
   logic [ROW_W-1:0] r_band_last_idx;
   logic [RES_W-1:0] r_res_cnt, r_res_exp, w_res_nxt;
   logic [WD_W-1:0]  r_wd_cnt;
   logic             r_guard;

   logic w_dims_ok, w_accept, w_in_wait, w_wait_exit, w_timeout;
   logic w_clear, w_col_step, w_band_step, w_col_last, w_band_last;
   logic [COL_W-1:0] w_col_nxt;
   logic [ROW_W-1:0] w_band_nxt;

   logic             w_coeff, w_sample, w_new_row, w_busy, w_done, w_err;
   logic [COL_W-1:0] w_samp_col;
   logic [ROW_W-1:0] w_samp_band;

   assign w_dims_ok   = (i_img_cols >= COL_W'(KERNEL_DIM)) && (i_img_rows >= ROW_W'(KERNEL_DIM));
   assign w_accept    = (r_state == IDLE) && i_start && w_dims_ok;
   assign w_in_wait   = is_wait_state(r_state);
   assign w_wait_exit = w_in_wait && !r_guard && !i_modwait;
   assign w_timeout   = w_in_wait && i_modwait && (r_wd_cnt == WD_W'(TIMEOUT - 1));
   // A result arriving on the exit cycle itself still counts toward done.
   assign w_res_nxt   = r_res_cnt + {{(RES_W-1){1'b0}}, (i_convolve_en && o_busy)};

   assign w_clear     = w_accept || ((r_state == COEFF_WAIT) && w_wait_exit);
   assign w_col_step  = (r_state == COL_WAIT) && w_wait_exit && !w_col_last;
   assign w_band_step = (r_state == COL_WAIT) && w_wait_exit && w_col_last && !w_band_last;

   conv_raster_counter #(.COL_W(COL_W), .ROW_W(ROW_W)) u_raster (
      .i_clk           (i_clk),
      .i_n_rst         (i_n_rst),
      .i_clear         (w_clear),
      .i_col_step      (w_col_step),
      .i_band_step     (w_band_step),
      .i_col_last_idx  (r_col_last_idx),
      .i_band_last_idx (r_band_last_idx),
      .o_col_nxt       (w_col_nxt),
      .o_band_nxt      (w_band_nxt),
      .o_col_last      (w_col_last),
      .o_band_last     (w_band_last)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; the watchdog overrides every state.
   always_comb begin
      w_next_state = r_state;
      if (w_timeout) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE:       w_next_state = w_accept ? COEFF_REQ : IDLE;
            COEFF_REQ:  w_next_state = COEFF_WAIT;
            COEFF_WAIT: w_next_state = w_wait_exit ? COL_REQ : COEFF_WAIT;
            COL_REQ:    w_next_state = COL_WAIT;
            BAND_REQ:   w_next_state = COL_WAIT;
            COL_WAIT: begin
               if (!w_wait_exit) begin
                  w_next_state = COL_WAIT;
               end else if (!w_col_last) begin
                  w_next_state = COL_REQ;
               end else if (!w_band_last) begin
                  w_next_state = BAND_REQ;
               end else begin
                  w_next_state = END_REQ;
               end
            end
            END_REQ:    w_next_state = END_WAIT;
            END_WAIT:   w_next_state = w_wait_exit ? IDLE : END_WAIT;
            default:    w_next_state = IDLE;
         endcase
      end
   end

   // Output decode from the next state so the registered strobes align with it.
   always_comb begin
      w_coeff     = (w_next_state == COEFF_REQ);
      w_sample    = (w_next_state == COL_REQ) || (w_next_state == END_REQ);
      w_new_row   = (w_next_state == BAND_REQ) || (w_next_state == END_REQ);
      w_busy      = (w_next_state != IDLE);
      w_samp_col  = {COL_W{1'b0}};
      w_samp_band = {ROW_W{1'b0}};
      if (w_next_state == COL_REQ) begin
         w_samp_col = w_col_nxt;
      end else begin
         w_samp_col = {COL_W{1'b0}};
      end
      if (w_busy) begin
         w_samp_band = w_band_nxt;
      end else begin
         w_samp_band = {ROW_W{1'b0}};
      end
      w_done = (r_state == END_WAIT) && w_wait_exit && (w_res_nxt == r_res_exp);
      w_err  = ((r_state == IDLE) && i_start && !w_dims_ok) || w_timeout ||
               ((r_state == END_WAIT) && w_wait_exit && (w_res_nxt != r_res_exp));
   end

   // Registered outputs.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         o_coeff_load_en  <= 1'b0;
         o_sample_load_en <= 1'b0;
         o_new_row        <= 1'b0;
         o_samp_col       <= {COL_W{1'b0}};
         o_samp_band      <= {ROW_W{1'b0}};
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_err            <= 1'b0;
      end else begin
         o_coeff_load_en  <= w_coeff;
         o_sample_load_en <= w_sample;
         o_new_row        <= w_new_row;
         o_samp_col       <= w_samp_col;
         o_samp_band      <= w_samp_band;
         o_busy           <= w_busy;
         o_done           <= w_done;
         o_err            <= w_err;
      end
   end

   // Frame dimensions, result counter, watchdog and WAIT guard.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_col_last_idx  <= {COL_W{1'b0}};
         r_band_last_idx <= {ROW_W{1'b0}};
         r_res_exp       <= {RES_W{1'b0}};
         r_res_cnt       <= {RES_W{1'b0}};
         r_wd_cnt        <= {WD_W{1'b0}};
         r_guard         <= 1'b0;
      end else begin
         if (w_accept) begin
            r_col_last_idx  <= i_img_cols - COL_W'(1);
            r_band_last_idx <= i_img_rows - ROW_W'(KERNEL_DIM);
            r_res_exp       <= RES_W'(i_img_cols - COL_W'(2)) * RES_W'(i_img_rows - ROW_W'(2));
            r_res_cnt       <= {RES_W{1'b0}};
         end else begin
            r_res_cnt       <= w_res_nxt;
         end
         if (w_in_wait && i_modwait && !w_timeout) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
         end else begin
            r_wd_cnt <= {WD_W{1'b0}};
         end
         r_guard <= is_wait_state(w_next_state) && !w_in_wait;
      end
   end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench: behavioural controller model plus a raster-order
// reference of the strobe events each frame should produce.
module tb_conv_frame_sequencer;

   localparam int COL_W   = 6;
   localparam int ROW_W   = 6;
   localparam int TIMEOUT = 15;

   logic             clk = 1'b0;
   logic             n_rst = 1'b0;
   logic             start = 1'b0;
   logic [COL_W-1:0] img_cols = '0;
   logic [ROW_W-1:0] img_rows = '0;
   logic             modwait = 1'b0;
   logic             convolve_en = 1'b0;
   logic             coeff_load_en, sample_load_en, new_row, busy, done, err;
   logic [COL_W-1:0] samp_col;
   logic [ROW_W-1:0] samp_band;

   int checks = 0;
   int failures = 0;

   // controller model state
   int mw_cnt = 0;
   bit res_pend = 1'b0;
   bit hang_arm = 1'b0;
   bit hung = 1'b0;
   int loaded = 0;
   int conv_seen = 0;

   always #5 clk = ~clk;

   conv_frame_sequencer #(.COL_W(COL_W), .ROW_W(ROW_W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk            (clk),
      .i_n_rst          (n_rst),
      .i_start          (start),
      .i_img_cols       (img_cols),
      .i_img_rows       (img_rows),
      .i_modwait        (modwait),
      .i_convolve_en    (convolve_en),
      .o_coeff_load_en  (coeff_load_en),
      .o_sample_load_en (sample_load_en),
      .o_new_row        (new_row),
      .o_samp_col       (samp_col),
      .o_samp_band      (samp_band),
      .o_busy           (busy),
      .o_done           (done),
      .o_err            (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {14'd0, coeff_load_en, sample_load_en, new_row, samp_col, samp_band, busy, done, err};
   endfunction

   function automatic int enc(input int kind, input int band, input int col);
      return kind * 4096 + band * 64 + col;
   endfunction

   task automatic model_reset();
      mw_cnt = 0; res_pend = 1'b0; hang_arm = 1'b0; hung = 1'b0; loaded = 0;
      modwait = 1'b0; convolve_en = 1'b0;
   endtask

   // One clock: sample outputs after the edge, then drive the controller model.
   task automatic tick();
      @(posedge clk);
      #1;
      modwait = hung || (mw_cnt > 0);
      if (mw_cnt > 0) mw_cnt--;
      convolve_en = res_pend;
      if (res_pend) conv_seen++;
      res_pend = 1'b0;
      if (coeff_load_en) begin
         mw_cnt = 3; loaded = 0;
      end else if (sample_load_en && new_row) begin
         mw_cnt = 1; loaded = 0;
      end else if (new_row) begin
         mw_cnt = 1; loaded = 1;
      end else if (sample_load_en) begin
         mw_cnt = 1; loaded++;
         if (loaded >= 3) res_pend = 1'b1;
      end
      if (hang_arm && sample_load_en) hung = 1'b1;
   endtask

   // mode 0: normal frame, 1: controller hangs after first column, 2: reset in band 1
   task automatic run_frame(input int cols, input int rows, input int mode);
      int exp_q[$];
      int ev, kind, first_s, busy_low, n_ev;
      bit fin;
      exp_q.push_back(enc(1, 0, 0));
      for (int b = 0; b <= rows - 3; b++) begin
         if (b == 0) exp_q.push_back(enc(2, 0, 0));
         else        exp_q.push_back(enc(3, b, 0));
         for (int c = 1; c < cols; c++) exp_q.push_back(enc(2, b, c));
      end
      exp_q.push_back(enc(4, rows - 3, 0));
      conv_seen = 0;
      hang_arm = (mode == 1);
      img_cols = COL_W'(cols);
      img_rows = ROW_W'(rows);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      fin = 1'b0; first_s = -1; busy_low = 0; n_ev = 0;
      for (int k = 0; k < 4000 && !fin; k++) begin
         if (coeff_load_en || sample_load_en || new_row) begin
            if (coeff_load_en && !sample_load_en && !new_row)      kind = 1;
            else if (!coeff_load_en && sample_load_en && !new_row) kind = 2;
            else if (!coeff_load_en && !sample_load_en && new_row) kind = 3;
            else if (!coeff_load_en && sample_load_en && new_row)  kind = 4;
            else                                                   kind = 7;
            ev = enc(kind, int'(samp_band), int'(samp_col));
            if (exp_q.size() == 0) check("event_extra", ev, 0);
            else check($sformatf("event%0d_%0dx%0d", n_ev, cols, rows), ev, exp_q.pop_front());
            n_ev++;
            if (mode == 1 && sample_load_en && first_s < 0) first_s = k;
            if (mode == 2 && new_row && samp_band == 6'd1) begin
               n_rst = 1'b0;
               tick();
               check("abort_outputs_zero", outs(), 0);
               n_rst = 1'b1;
               model_reset();
               tick();
               check("abort_stays_quiet", outs(), 0);
               return;
            end
         end
         if (done || err) begin
            fin = 1'b1;
            check("end_strobes_busy", {coeff_load_en, sample_load_en, new_row, busy}, 0);
            if (mode == 1) begin
               check("wd_err", {done, err}, 2'b01);
               check("wd_latency", k - first_s, TIMEOUT + 1);
            end else begin
               check("frame_done", {done, err}, 2'b10);
               check("events_left", exp_q.size(), 0);
               check("results", conv_seen, (cols - 2) * (rows - 2));
               check("busy_throughout", busy_low, 0);
            end
         end else begin
            if (!busy) busy_low++;
            if (k == 6) begin
               img_cols = 6'd3; img_rows = 6'd3; start = 1'b1;
            end else begin
               start = 1'b0;
            end
            tick();
            start = 1'b0;
         end
      end
      if (!fin) check("frame_bound", 0, 1);
      model_reset();
      tick();
      check("after_frame_idle", outs(), 0);
   endtask

   initial begin
      int c, r;
      // reset held across two edges with start asserted
      n_rst = 1'b0; start = 1'b1; img_cols = 6'd3; img_rows = 6'd3;
      tick(); tick();
      check("reset_outputs", outs(), 0);
      n_rst = 1'b1; start = 1'b0;
      tick();
      check("post_reset_idle", outs(), 0);

      run_frame(3, 3, 0);
      run_frame(4, 5, 0);

      // illegal dimensions
      img_cols = 6'd2; img_rows = 6'd8; start = 1'b1;
      tick();
      start = 1'b0;
      check("illegal_err", {err, done, busy, coeff_load_en, sample_load_en, new_row}, 6'b100000);
      tick();
      check("illegal_after", outs(), 0);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin c = $urandom_range(2, 0); r = $urandom_range(63, 0); end
         else            begin c = $urandom_range(63, 0); r = $urandom_range(2, 0); end
         img_cols = COL_W'(c); img_rows = ROW_W'(r); start = 1'b1;
         tick();
         start = 1'b0;
         check($sformatf("illegal_rand_%0dx%0d", c, r), {err, busy, coeff_load_en, sample_load_en, new_row}, 5'b10000);
      end
      tick();
      check("illegal_rand_after", outs(), 0);

      run_frame(5, 4, 1);
      run_frame(5, 4, 2);
      run_frame(5, 4, 0);

      for (int i = 0; i < 4; i++) begin
         run_frame($urandom_range(9, 3), $urandom_range(7, 3), 0);
      end
      run_frame(63, 4, 0);
      run_frame(3, 63, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
